// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU command serializer: opcodes, error modes, frame format.
package alu_pkg;

  typedef enum logic [2:0] {
    OP_AND = 3'b000,
    OP_OR  = 3'b001,
    OP_BAD = 3'b010,
    OP_ADD = 3'b100,
    OP_SUB = 3'b101
  } operation_t;

  typedef enum logic [1:0] {
    ERR_NONE = 2'b00,
    ERR_DATA = 2'b01,
    ERR_CRC  = 2'b10,
    ERR_OP   = 2'b11
  } err_mode_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_DATA,
    S_CMD
  } ser_state_t;

  localparam int         FRAME_BITS = 11;
  localparam logic [3:0] CRC4_POLY  = 4'h3;
  localparam logic       DATA_TYPE  = 1'b0;
  localparam logic       CMD_TYPE   = 1'b1;

  // Line order is MSB first: start, type, d[7:0], stop.
  function automatic logic [FRAME_BITS-1:0] make_frame(input logic typ, input logic [7:0] d);
    return {1'b0, typ, d, 1'b1};
  endfunction

endpackage

// File: rtl/crc4_serial.sv
// Bit-serial CRC4 (x^4+x+1, init 0, MSB first) over NBITS bits, one bit per clock after start.
// crc_done rises once NBITS bits have been absorbed; further valid bits are ignored.
module crc4_serial
  import alu_pkg::*;
#(
  parameter int NBITS = 68
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       valid,
  input  logic       bit_in,
  output logic [3:0] crc,
  output logic       crc_done
);

  localparam int CW = $clog2(NBITS + 1);

  logic [3:0]    crc_q, crc_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          fb;

  assign crc      = crc_q;
  assign crc_done = (cnt_q == CW'(NBITS));
  assign fb       = crc_q[3] ^ bit_in;

  always_comb begin
    crc_d = crc_q;
    cnt_d = cnt_q;
    if (start) begin
      crc_d = '0;
      cnt_d = '0;
    end else if (valid && !crc_done) begin
      crc_d = {crc_q[2:0], 1'b0} ^ (fb ? CRC4_POLY : 4'h0);
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      crc_q <= '0;
      cnt_q <= CW'(NBITS);
    end else begin
      crc_q <= crc_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/alu_cmd_serializer.sv
// Serialises one {A,B,op} request into 2N data frames + 1 CMD frame on sin; first start bit from the accept edge.
// req_ready only while idle, so requests wait while a packet is in flight; done pulses F*11*CLKS_PER_BIT after accept.
module alu_cmd_serializer
  import alu_pkg::*;
#(
  parameter int OPERAND_BYTES = 4,
  parameter int CLKS_PER_BIT  = 1,
  parameter int CNT_W         = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic [8*OPERAND_BYTES-1:0] A,
  input  logic [8*OPERAND_BYTES-1:0] B,
  input  logic [2:0]                 op,
  input  logic [1:0]                 err_mode,
  output logic                       sin,
  output logic                       busy,
  output logic                       done,
  output logic [CNT_W-1:0]           pkt_cnt
);

  localparam int N      = OPERAND_BYTES;
  localparam int W      = 8 * N;
  localparam int NBITS  = 2 * W + 4;
  localparam int TW     = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int YW     = $clog2(2 * N);

  ser_state_t            state_q, state_d;
  logic                  rdy_en_q;
  logic [TW-1:0]         timer_q, timer_d;
  logic [3:0]            bit_q, bit_d;
  logic [YW-1:0]         byte_q, byte_d;
  logic [FRAME_BITS-1:0] frame_q, frame_d;
  logic [2*W-1:0]        data_q, data_d;
  logic [NBITS-1:0]      crc_src_q, crc_src_d;
  logic [2:0]            op_q, op_d;
  err_mode_t             err_q, err_d;
  logic                  done_q, done_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;

  logic       accept, bit_end, last_byte, crc_valid, crc_done;
  logic [2:0] op_tx_in;
  logic [3:0] crc, crc_tx;
  logic [7:0] cmd_byte;

  assign req_ready = rdy_en_q && (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign accept    = req_valid && req_ready;
  assign sin       = frame_q[FRAME_BITS-1];
  assign done      = done_q;
  assign pkt_cnt   = cnt_q;

  assign bit_end   = (timer_q == TW'(CLKS_PER_BIT - 1));
  assign last_byte = (byte_q == ((err_q == ERR_DATA) ? YW'(2 * N - 2) : YW'(2 * N - 1)));
  assign op_tx_in  = (err_mode_t'(err_mode) == ERR_OP) ? OP_BAD : op;
  assign crc_tx    = (err_q == ERR_CRC) ? crc + 4'd1 : crc;
  assign cmd_byte  = {1'b0, op_q, crc_tx};
  assign crc_valid = busy && !crc_done;

  crc4_serial #(.NBITS(NBITS)) u_crc (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (accept),
    .valid    (crc_valid),
    .bit_in   (crc_src_q[NBITS-1]),
    .crc      (crc),
    .crc_done (crc_done)
  );

  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    bit_d     = bit_q;
    byte_d    = byte_q;
    frame_d   = frame_q;
    data_d    = data_q;
    crc_src_d = crc_valid ? (crc_src_q << 1) : crc_src_q;
    op_d      = op_q;
    err_d     = err_q;
    done_d    = 1'b0;
    cnt_d     = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d   = S_DATA;
          timer_d   = '0;
          bit_d     = '0;
          byte_d    = '0;
          frame_d   = make_frame(DATA_TYPE, B[W-1 -: 8]);
          data_d    = {B, A} << 8;
          crc_src_d = {B, A, 1'b1, op_tx_in};
          op_d      = op_tx_in;
          err_d     = err_mode_t'(err_mode);
        end
      end
      default: begin
        if (!bit_end) begin
          timer_d = timer_q + TW'(1);
        end else begin
          timer_d = '0;
          if (bit_q != 4'(FRAME_BITS - 1)) begin
            bit_d   = bit_q + 4'd1;
            frame_d = {frame_q[FRAME_BITS-2:0], 1'b1};
          end else if (state_q == S_CMD) begin
            state_d = S_IDLE;
            bit_d   = '0;
            frame_d = '1;
            done_d  = 1'b1;
            cnt_d   = cnt_q + CNT_W'(1);
          end else if (!last_byte) begin
            bit_d   = '0;
            byte_d  = byte_q + YW'(1);
            frame_d = make_frame(DATA_TYPE, data_q[2*W-1 -: 8]);
            data_d  = data_q << 8;
          end else if (crc_done) begin
            state_d = S_CMD;
            bit_d   = '0;
            byte_d  = '0;
            frame_d = make_frame(CMD_TYPE, cmd_byte);
          end else begin
            // Very short packets can outrun the CRC: hold the line at the stop level until it settles.
            timer_d = timer_q;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      rdy_en_q <= 1'b0;
      timer_q  <= '0;
      bit_q    <= '0;
      byte_q   <= '0;
      frame_q  <= '1;
      done_q   <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      rdy_en_q <= 1'b1;
      timer_q  <= timer_d;
      bit_q    <= bit_d;
      byte_q   <= byte_d;
      frame_q  <= frame_d;
      done_q   <= done_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    data_q    <= data_d;
    crc_src_q <= crc_src_d;
    op_q      <= op_d;
    err_q     <= err_d;
  end

endmodule
